// File: rtl/memory_stage.sv
// Memory stage: EX/MEM and MEM/WB registers plus a bounded-wait request/ready data-memory port.
// One cycle EX/MEM -> MEM/WB when no access is pending; stall holds the front end while an access waits.
module memory_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRegWrite,
  input  logic        IMemWrite,
  input  logic        IMemRead,
  input  logic        IRegStore,
  input  logic [15:0] IPCP2,
  input  logic [15:0] IALUResult,
  input  logic [15:0] I3rdArg,
  input  logic [15:0] IRd,
  input  logic        flush,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_fault,
  output logic [15:0] ALUResultMEM,
  output logic [15:0] rdMEM,
  output logic        RegWriteMEM,
  output logic        MemReadMEM,
  output logic        ORegWrite,
  output logic        ORegStore,
  output logic [15:0] OPCP2,
  output logic [15:0] OALUResult,
  output logic [15:0] loadDataWB,
  output logic [15:0] ORd
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, stateNext;
  logic [7:0]  waitCnt, waitCntNext;
  logic        memWriteMEM, regStoreMEM;
  logic [15:0] pcp2MEM, arg3MEM;
  logic        loadIsMemOp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= 8'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    stall       = 1'b0;
    mem_fault   = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = 16'h0000;
    dmem_wdata  = 16'h0000;
    stateNext   = state;
    waitCntNext = waitCnt;
    loadIsMemOp = !flush && (IMemRead || IMemWrite);

    if (state == ACCESS) begin
      dmem_req   = 1'b1;
      dmem_we    = memWriteMEM;
      dmem_addr  = ALUResultMEM;
      dmem_wdata = arg3MEM;
      // Ready takes priority over the last allowed wait cycle.
      if (dmem_ready || waitCnt == LAST_WAIT) begin
        mem_fault = !dmem_ready;
      end else begin
        stall       = 1'b1;
        waitCntNext = waitCnt + 8'd1;
      end
    end

    if (!stall) begin
      stateNext   = loadIsMemOp ? ACCESS : IDLE;
      waitCntNext = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteMEM  <= 1'b0;
      memWriteMEM  <= 1'b0;
      MemReadMEM   <= 1'b0;
      regStoreMEM  <= 1'b0;
      pcp2MEM      <= 16'h0000;
      ALUResultMEM <= 16'h0000;
      arg3MEM      <= 16'h0000;
      rdMEM        <= 16'h0000;
    end else if (!stall) begin
      RegWriteMEM  <= IRegWrite && !flush;
      memWriteMEM  <= IMemWrite && !flush;
      MemReadMEM   <= IMemRead && !flush;
      regStoreMEM  <= IRegStore && !flush;
      pcp2MEM      <= IPCP2;
      ALUResultMEM <= IALUResult;
      arg3MEM      <= I3rdArg;
      rdMEM        <= IRd;
    end
  end

  // While stalled only the control bits drop, so the waiting entry is never written back twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      ORegWrite  <= 1'b0;
      ORegStore  <= 1'b0;
      OPCP2      <= 16'h0000;
      OALUResult <= 16'h0000;
      loadDataWB <= 16'h0000;
      ORd        <= 16'h0000;
    end else if (stall) begin
      ORegWrite <= 1'b0;
      ORegStore <= 1'b0;
    end else begin
      ORegWrite  <= RegWriteMEM && !mem_fault;
      ORegStore  <= regStoreMEM;
      OPCP2      <= pcp2MEM;
      OALUResult <= ALUResultMEM;
      ORd        <= rdMEM;
      if (mem_fault)
        loadDataWB <= 16'hFFFF;
      else if (MemReadMEM && !memWriteMEM)
        loadDataWB <= dmem_rdata;
      else
        loadDataWB <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios then random instructions against an instruction-level model.
module tb_memory_stage;
  localparam int TO = 4;

  typedef struct packed {
    logic        rw, mw, mr, rs;
    logic [15:0] pc, alu, a3, rd;
  } ins_t;

  logic        clk = 1'b0;
  logic        reset, IRegWrite, IMemWrite, IMemRead, IRegStore, flush;
  logic [15:0] IPCP2, IALUResult, I3rdArg, IRd, dmem_rdata;
  logic        dmem_ready;
  logic        stall, dmem_req, dmem_we, mem_fault;
  logic [15:0] dmem_addr, dmem_wdata, ALUResultMEM, rdMEM;
  logic        RegWriteMEM, MemReadMEM, ORegWrite, ORegStore;
  logic [15:0] OPCP2, OALUResult, loadDataWB, ORd;

  memory_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .IRegWrite(IRegWrite), .IMemWrite(IMemWrite), .IMemRead(IMemRead), .IRegStore(IRegStore),
    .IPCP2(IPCP2), .IALUResult(IALUResult), .I3rdArg(I3rdArg), .IRd(IRd),
    .flush(flush), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .mem_fault(mem_fault),
    .ALUResultMEM(ALUResultMEM), .rdMEM(rdMEM), .RegWriteMEM(RegWriteMEM), .MemReadMEM(MemReadMEM),
    .ORegWrite(ORegWrite), .ORegStore(ORegStore), .OPCP2(OPCP2), .OALUResult(OALUResult),
    .loadDataWB(loadDataWB), .ORd(ORd)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, stallCount = 0, faultCount = 0;
  ins_t        front, cur;
  logic        curFlush;
  int          waitCnt, lat, nextLat;
  logic        eORW, eORS;
  logic [15:0] ePC, eALU, eLD, eRD;
  logic [15:0] memImg [16];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic rw, mw, mr, rs, input logic [15:0] alu, a3, rd);
    ins_t m;
    m.rw = rw; m.mw = mw; m.mr = mr; m.rs = rs;
    m.pc = 16'($urandom); m.alu = alu; m.a3 = a3; m.rd = rd;
    return m;
  endfunction

  // One clock of the environment: memory responds per the chosen latency, model retires the EX/MEM entry.
  task automatic cycle(output logic consumed);
    logic memop, rdy, fin, flt;
    memop = front.mr | front.mw;
    rdy = memop ? (waitCnt == lat) : 1'($urandom);
    dmem_ready = rdy;
    dmem_rdata = (memop && rdy) ? memImg[front.alu[3:0]] : 16'($urandom);
    IRegWrite = cur.rw; IMemWrite = cur.mw; IMemRead = cur.mr; IRegStore = cur.rs;
    IPCP2 = cur.pc; IALUResult = cur.alu; I3rdArg = cur.a3; IRd = cur.rd; flush = curFlush;
    @(negedge clk);
    fin = memop && (rdy || waitCnt == TO - 1);
    flt = memop && !rdy && waitCnt == TO - 1;
    chk("stall", stall, memop && !fin);
    chk("dmem_req", dmem_req, memop);
    chk("mem_fault", mem_fault, flt);
    if (memop) begin
      chk("dmem_addr", dmem_addr, front.alu);
      chk("dmem_we", dmem_we, front.mw);
      chk("dmem_wdata", dmem_wdata, front.a3);
    end
    chk("RegWriteMEM", RegWriteMEM, front.rw);
    chk("MemReadMEM", MemReadMEM, front.mr);
    chk("rdMEM", rdMEM, front.rd);
    chk("ALUResultMEM", ALUResultMEM, front.alu);
    chk("ORegWrite", ORegWrite, eORW);
    chk("ORegStore", ORegStore, eORS);
    chk("OPCP2", OPCP2, ePC);
    chk("OALUResult", OALUResult, eALU);
    chk("ORd", ORd, eRD);
    chk("loadDataWB", loadDataWB, eLD);
    if (stall) stallCount++;
    if (mem_fault) faultCount++;
    if (!(memop && !fin)) begin
      eORW = front.rw && !flt; eORS = front.rs;
      ePC = front.pc; eALU = front.alu; eRD = front.rd;
      eLD = flt ? 16'hFFFF : (front.mr && !front.mw) ? memImg[front.alu[3:0]] : 16'h0000;
      if (front.mw && !flt) memImg[front.alu[3:0]] = front.a3;
      front = cur;
      if (curFlush) begin front.rw = 0; front.mw = 0; front.mr = 0; front.rs = 0; end
      waitCnt = 0;
      lat = (nextLat >= 0) ? nextLat : int'($urandom_range(0, 5));
      consumed = 1'b1;
    end else begin
      eORW = 1'b0; eORS = 1'b0;
      waitCnt++;
      consumed = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input ins_t i, input logic fl, output int waited);
    logic c;
    cur = i; curFlush = fl; waited = 0;
    do begin
      cycle(c);
      waited++;
    end while (!c && waited < 50);
    chk("issue_bound", 16'(c), 16'd1);
    cur = '0; curFlush = 1'b0;
  endtask

  task automatic doReset(input int n);
    reset = 1'b1; dmem_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    front = '0; waitCnt = 0; lat = 0;
    eORW = 0; eORS = 0; ePC = 0; eALU = 0; eLD = 0; eRD = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, s0, f0, k;
    logic c;
    ins_t bub;
    bub = '0; cur = '0; curFlush = 0; nextLat = 0;
    IRegWrite = 0; IMemWrite = 0; IMemRead = 0; IRegStore = 0; flush = 0;
    IPCP2 = 0; IALUResult = 0; I3rdArg = 0; IRd = 0; dmem_rdata = 0; dmem_ready = 0;
    for (int i = 0; i < 16; i++) memImg[i] = 16'($urandom);
    memImg[0] = 16'hBEEF;
    doReset(2);
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_orw", ORegWrite, 0);
    chk("rst_ld", loadDataWB, 0);
    chk("rst_alumem", ALUResultMEM, 0);

    // ALU instruction then a bubble
    s0 = stallCount;
    issue(mk(1, 0, 0, 0, 16'h1234, 16'h0, 16'd3), 0, w);
    chk("alu_rwmem", RegWriteMEM, 1);
    chk("alu_rdmem", rdMEM, 16'd3);
    chk("alu_resmem", ALUResultMEM, 16'h1234);
    issue(bub, 0, w);
    chk("alu_orw", ORegWrite, 1);
    chk("alu_ores", OALUResult, 16'h1234);
    chk("alu_nostall", 16'(stallCount - s0), 0);

    // zero-wait load
    nextLat = 0;
    issue(mk(1, 0, 1, 0, 16'h0040, 16'h0, 16'd5), 0, w);
    chk("zl_req", dmem_req, 1);
    chk("zl_addr", dmem_addr, 16'h0040);
    issue(bub, 0, w);
    chk("zl_wait", 16'(w), 1);
    chk("zl_ld", loadDataWB, 16'hBEEF);
    chk("zl_orw", ORegWrite, 1);
    chk("zl_req_drop", dmem_req, 0);

    // load with 3 wait cycles followed by an ALU op
    nextLat = 3;
    issue(mk(1, 0, 1, 0, 16'h0003, 16'h0, 16'd6), 0, w);
    s0 = stallCount;
    issue(mk(1, 0, 0, 0, 16'h7777, 16'h0, 16'd7), 0, w);
    chk("lw_stall", 16'(stallCount - s0), 3);
    chk("lw_ld", loadDataWB, memImg[3]);
    chk("lw_orw", ORegWrite, 1);
    chk("lw_ord", ORd, 16'd6);
    chk("lw_next_in", rdMEM, 16'd7);

    // store, then a second store flushed while the first is still waiting
    nextLat = 2;
    issue(mk(0, 1, 0, 0, 16'h0007, 16'h1111, 16'd0), 0, w);
    s0 = stallCount;
    issue(mk(0, 1, 0, 0, 16'h0100, 16'hA5A5, 16'd0), 1, w);
    chk("st_stall", 16'(stallCount - s0), 2);
    chk("st2_noreq", dmem_req, 0);
    issue(bub, 0, w);
    chk("st2_noreq2", dmem_req, 0);

    // timeout, then ready on the last allowed cycle
    nextLat = 99;
    issue(mk(1, 0, 1, 0, 16'h0005, 16'h0, 16'd9), 0, w);
    s0 = stallCount; f0 = faultCount;
    issue(bub, 0, w);
    chk("to_stall", 16'(stallCount - s0), 3);
    chk("to_fault", 16'(faultCount - f0), 1);
    chk("to_orw", ORegWrite, 0);
    chk("to_ld", loadDataWB, 16'hFFFF);
    nextLat = 3;
    issue(mk(1, 0, 1, 0, 16'h0005, 16'h0, 16'd9), 0, w);
    s0 = stallCount; f0 = faultCount;
    issue(bub, 0, w);
    chk("rt_stall", 16'(stallCount - s0), 3);
    chk("rt_fault", 16'(faultCount - f0), 0);
    chk("rt_orw", ORegWrite, 1);
    chk("rt_ld", loadDataWB, memImg[5]);

    // reset in the third wait cycle of a load
    nextLat = 99;
    issue(mk(1, 0, 1, 0, 16'h0009, 16'h0, 16'd10), 0, w);
    cycle(c);
    cycle(c);
    doReset(1);
    chk("rm_req", dmem_req, 0);
    chk("rm_stall", stall, 0);
    chk("rm_fault", mem_fault, 0);
    chk("rm_orw", ORegWrite, 0);
    chk("rm_alumem", ALUResultMEM, 0);
    chk("rm_rdmem", rdMEM, 0);
    issue(mk(1, 0, 1, 0, 16'h000A, 16'h0, 16'd11), 0, w);
    s0 = stallCount; f0 = faultCount;
    issue(bub, 0, w);
    chk("rm_next_stall", 16'(stallCount - s0), 3);
    chk("rm_next_fault", 16'(faultCount - f0), 1);

    // random instruction stream with random memory latency
    nextLat = -1;
    for (int n = 0; n < 200; n++) begin
      k = int'($urandom_range(0, 3));
      case (k)
        0: issue(mk(1'($urandom), 0, 0, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom_range(0, 15))), 0, w);
        1: issue(mk(1, 0, 1, 0, 16'($urandom), 16'($urandom), 16'($urandom_range(0, 15))), 0, w);
        2: issue(mk(0, 1, 0, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom_range(0, 15))), 0, w);
        default: issue(mk(1, 1'($urandom), 1'($urandom), 1, 16'($urandom), 16'($urandom), 16'($urandom_range(0, 15))), 1, w);
      endcase
    end
    issue(bub, 0, w);
    issue(bub, 0, w);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
